// File: rtl/crypto_job_pkg.sv
// Shared types and defaults for the crypto job arbiter.
// Imported by the arbiter top and its round-robin helper.
package crypto_job_pkg;

    localparam int unsigned DATA_W_DEF    = 32;
    localparam int unsigned MAX_WORDS_DEF = 16;

    localparam logic MODE_HASH = 1'b0;
    localparam logic MODE_AEAD = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        LOAD,
        WAIT,
        DRAIN,
        ERR
    } state_t;

endpackage

// File: rtl/crypto_rr_arb2.sv
// Two-way round-robin arbiter: the pointer requester wins, else the other one.
// The pointer moves past the served requester when the top reports job completion.
module crypto_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       adv,
    input  logic       served,
    output logic       gnt_valid,
    output logic       gnt_id,
    output logic       ptr
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (adv) begin
            ptr <= ~served;
        end
    end

    always_comb begin
        gnt_valid = |req;
        gnt_id    = req[ptr] ? ptr : ~ptr;
    end

endmodule

// File: rtl/crypto_job_arbiter.sv
// Arbitrates two requesters onto a single crypto core: grant, start, load words,
// wait for completion (with timeout), then drain results or emit an error beat.
module crypto_job_arbiter
    import crypto_job_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned MAX_WORDS = MAX_WORDS_DEF,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic                ACLK,
    input  logic                ARESET,

    input  logic [1:0]          req_valid,
    input  logic [1:0]          req_mode,
    output logic [1:0]          req_ready,

    input  logic [1:0]          s_valid,
    input  logic [1:0]          s_last,
    input  logic [2*DATA_W-1:0] s_data,
    output logic [1:0]          s_ready,

    output logic [1:0]          m_valid,
    input  logic [1:0]          m_ready,
    output logic [DATA_W-1:0]   m_data,
    output logic                m_last,
    output logic                m_err,

    output logic                core_mode,
    output logic                core_start,

    output logic                core_in_valid,
    input  logic                core_in_ready,
    output logic [DATA_W-1:0]   core_in_data,
    output logic                core_in_last,

    input  logic                core_done,
    input  logic                core_out_valid,
    output logic                core_out_ready,
    input  logic [DATA_W-1:0]   core_out_data,
    input  logic                core_out_last,

    output logic                busy,
    output logic                grant_id
);

    localparam int unsigned CW = $clog2(MAX_WORDS + 1);
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t          state;
    logic [CW-1:0]   wcnt;
    logic [TW-1:0]   timer;

    logic            arb_valid;
    logic            arb_id;
    logic            arb_ptr;
    logic            arb_adv;

    logic            g;
    logic            in_hs;
    logic            out_hs;
    logic            cnt_at_max;
    logic            timer_at_max;

    assign g            = grant_id;
    assign in_hs        = (state == LOAD) && s_valid[g] && core_in_ready;
    assign out_hs       = (state == DRAIN) && core_out_valid && m_ready[g];
    assign cnt_at_max   = (wcnt == CW'(MAX_WORDS - 1));
    assign timer_at_max = (timer == TW'(TIMEOUT - 1));
    assign arb_adv      = (out_hs && core_out_last) || ((state == ERR) && m_ready[g]);

    crypto_rr_arb2 u_arb (
        .clk       (ACLK),
        .rst       (ARESET),
        .req       (req_valid),
        .adv       (arb_adv),
        .served    (g),
        .gnt_valid (arb_valid),
        .gnt_id    (arb_id),
        .ptr       (arb_ptr)
    );

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state      <= IDLE;
            grant_id   <= 1'b0;
            core_start <= 1'b0;
            core_mode  <= 1'b0;
            busy       <= 1'b0;
            wcnt       <= '0;
            timer      <= '0;
        end else begin
            core_start <= 1'b0;
            core_mode  <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        grant_id   <= arb_id;
                        core_start <= 1'b1;
                        core_mode  <= req_mode[arb_id];
                        busy       <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    wcnt  <= '0;
                    timer <= '0;
                    state <= LOAD;
                end
                LOAD: begin
                    if (in_hs) begin
                        wcnt <= wcnt + CW'(1);
                        if (s_last[g]) begin
                            timer <= '0;
                            state <= WAIT;
                        end else if (cnt_at_max) begin
                            state <= ERR;
                        end
                    end
                end
                WAIT: begin
                    // core_done takes priority over an expiring timer
                    if (core_done) begin
                        state <= DRAIN;
                    end else if (timer_at_max) begin
                        state <= ERR;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                DRAIN: begin
                    if (out_hs && core_out_last) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                ERR: begin
                    if (m_ready[g]) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Data paths are zero-latency muxes selected by the registered state.
    always_comb begin
        req_ready      = '0;
        s_ready        = '0;
        m_valid        = '0;
        m_data         = '0;
        m_last         = 1'b0;
        m_err          = 1'b0;
        core_in_valid  = 1'b0;
        core_in_data   = '0;
        core_in_last   = 1'b0;
        core_out_ready = 1'b0;
        case (state)
            IDLE: begin
                if (arb_valid && !ARESET) begin
                    req_ready[arb_id] = 1'b1;
                end
            end
            LOAD: begin
                core_in_valid = s_valid[g];
                s_ready[g]    = core_in_ready;
                core_in_data  = g ? s_data[2*DATA_W-1:DATA_W] : s_data[DATA_W-1:0];
                core_in_last  = s_last[g] | cnt_at_max;
            end
            DRAIN: begin
                m_valid[g]     = core_out_valid;
                core_out_ready = m_ready[g];
                m_data         = core_out_data;
                m_last         = core_out_last;
            end
            ERR: begin
                m_valid[g] = 1'b1;
                m_last     = 1'b1;
                m_err      = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_crypto_job_arbiter.sv
// Directed bench for crypto_job_arbiter: a LOAD-phase vector table plus
// hand-written sequences for arbitration, overflow, timeout, backpressure and reset.
module tb_crypto_job_arbiter;

    localparam int unsigned DW = 32;

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic [1:0]    req_valid, req_mode, req_ready;
    logic [1:0]    s_valid, s_last, s_ready;
    logic [2*DW-1:0] s_data;
    logic [1:0]    m_valid, m_ready;
    logic [DW-1:0] m_data;
    logic          m_last, m_err;
    logic          core_mode, core_start;
    logic          core_in_valid, core_in_ready, core_in_last;
    logic [DW-1:0] core_in_data;
    logic          core_done, core_out_valid, core_out_ready, core_out_last;
    logic [DW-1:0] core_out_data;
    logic          busy, grant_id;

    int checks = 0;
    int errors = 0;

    crypto_job_arbiter #(.DATA_W(DW), .MAX_WORDS(16), .TIMEOUT(8)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .req_valid(req_valid), .req_mode(req_mode), .req_ready(req_ready),
        .s_valid(s_valid), .s_last(s_last), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .m_err(m_err),
        .core_mode(core_mode), .core_start(core_start),
        .core_in_valid(core_in_valid), .core_in_ready(core_in_ready),
        .core_in_data(core_in_data), .core_in_last(core_in_last),
        .core_done(core_done), .core_out_valid(core_out_valid), .core_out_ready(core_out_ready),
        .core_out_data(core_out_data), .core_out_last(core_out_last),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [1:0]  sv;
        logic [1:0]  sl;
        logic [31:0] d0;
        logic        cir;
        logic        done;
        logic        exp_civ;
        logic        exp_cil;
        logic [1:0]  exp_srdy;
        logic [31:0] exp_cdata;
    } load_vec_t;

    load_vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid = '0; req_mode = '0; s_valid = '0; s_last = '0; s_data = '0;
        m_ready = '0; core_in_ready = 1'b0; core_done = 1'b0; core_out_valid = 1'b0;
        core_out_data = '0; core_out_last = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_req_ready"}, req_ready, 0);
        check({name, "_s_ready"}, s_ready, 0);
        check({name, "_m_valid"}, m_valid, 0);
        check({name, "_m_flags"}, {m_data, m_last, m_err}, 0);
        check({name, "_core_ctl"}, {core_mode, core_start, core_in_valid, core_in_last, core_out_ready}, 0);
        check({name, "_core_in_data"}, core_in_data, 0);
        check({name, "_busy_gid"}, {busy, grant_id}, 0);
    endtask

    // Grants requester id (only it requesting), then advances into LOAD.
    task automatic start_job(input logic id, input logic mode);
        req_valid = '0; req_valid[id] = 1'b1;
        req_mode  = '0; req_mode[id]  = mode;
        tick();
        req_valid = '0;
        tick();
    endtask

    initial begin
        vecs[0] = '{2'b00, 2'b00, 32'h11111111, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 32'h11111111};
        vecs[1] = '{2'b01, 2'b00, 32'h11111111, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 32'h11111111};
        vecs[2] = '{2'b11, 2'b00, 32'h11111111, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 32'h11111111};
        vecs[3] = '{2'b01, 2'b10, 32'h22222222, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 32'h22222222};
        vecs[4] = '{2'b01, 2'b00, 32'h33333333, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 32'h33333333};
        vecs[5] = '{2'b01, 2'b01, 32'h44444444, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 32'h44444444};

        clear_inputs();
        ARESET = 1'b1;
        repeat (2) tick();
        req_valid = 2'b11;
        #1;
        check_all_zero("reset");
        req_valid = '0;
        ARESET = 1'b0;
        tick();

        // Job 1: requester 0, hash, 4 words, done 10 cycles after start, 2 results
        req_valid = 2'b01; req_mode = 2'b10;
        #1;
        check("j1_req_ready", req_ready, 2'b01);
        tick();
        req_valid = '0;
        #1;
        check("j1_start", {core_start, core_mode, busy, grant_id}, 4'b1010);
        check("j1_req_ready_drop", req_ready, 0);
        tick();
        s_data[63:32] = 32'hDEADBEEF;
        for (int i = 0; i < 6; i++) begin
            s_valid = vecs[i].sv; s_last = vecs[i].sl; s_data[31:0] = vecs[i].d0;
            core_in_ready = vecs[i].cir; core_done = vecs[i].done;
            #1;
            check($sformatf("load_v%0d_valid_last", i), {core_in_valid, core_in_last},
                  {vecs[i].exp_civ, vecs[i].exp_cil});
            check($sformatf("load_v%0d_s_ready", i), s_ready, vecs[i].exp_srdy);
            check($sformatf("load_v%0d_data", i), core_in_data, vecs[i].exp_cdata);
            check($sformatf("load_v%0d_quiet", i), {core_start, core_out_ready, m_valid}, 0);
            tick();
        end
        s_valid = 2'b11; s_last = '0; core_done = 1'b0;
        core_out_valid = 1'b1; m_ready = 2'b01;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("j1_wait%0d", k),
                  {core_in_valid, s_ready, core_out_ready, m_valid, busy}, 7'b0000001);
            tick();
        end
        s_valid = '0; core_done = 1'b1; m_ready = '0;
        tick();
        core_done = 1'b0;
        core_out_data = 32'hA5A5A5A5;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("j1_stall%0d", k), {m_valid, core_out_ready, m_last, m_err}, 5'b01000);
            check($sformatf("j1_stall%0d_data", k), m_data, 32'hA5A5A5A5);
            tick();
        end
        m_ready = 2'b01;
        #1;
        check("j1_word1", {m_valid, core_out_ready, m_last, m_err}, 5'b01100);
        tick();
        core_out_data = 32'h5A5A5A5A; core_out_last = 1'b1;
        #1;
        check("j1_word2", {m_valid, core_out_ready, m_last, m_err}, 5'b01110);
        check("j1_word2_data", m_data, 32'h5A5A5A5A);
        tick();
        core_out_valid = 1'b0; core_out_last = 1'b0; m_ready = '0;
        #1;
        check("j1_idle", {busy, grant_id, m_valid}, 0);
        req_valid = 2'b11;
        #1;
        check("j1_ptr_is_1", req_ready, 2'b10);
        req_valid = '0;
        tick();
        check("withdraw_no_grant", {busy, core_start}, 0);

        // Simultaneous requests after reset: req0 first, then req1 (AEAD overflow job)
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        tick();
        req_valid = 2'b11; req_mode = 2'b10;
        #1;
        check("both_req_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b10;
        #1;
        check("both_first", {grant_id, core_mode, core_start}, 3'b001);
        tick();
        s_valid = 2'b01; s_last = 2'b01; core_in_ready = 1'b1;
        tick();
        s_valid = '0; s_last = '0; core_done = 1'b1;
        tick();
        core_done = 1'b0; core_out_valid = 1'b1; core_out_last = 1'b1; m_ready = 2'b01;
        tick();
        core_out_valid = 1'b0; core_out_last = 1'b0; m_ready = '0;
        req_valid = 2'b11;
        #1;
        check("both_second_ready", req_ready, 2'b10);
        tick();
        req_valid = '0;
        #1;
        check("both_second", {grant_id, core_mode, core_start}, 3'b111);
        tick();
        for (int i = 0; i < 16; i++) begin
            s_valid = 2'b11; s_last = '0; s_data = {32'(i + 1), 32'hFFFFFFFF};
            #1;
            check($sformatf("ovf_w%0d_ctl", i), {core_in_valid, core_in_last, s_ready},
                  {1'b1, (i == 15), 2'b10});
            check($sformatf("ovf_w%0d_data", i), core_in_data, 32'(i + 1));
            tick();
        end
        s_valid = '0; s_data = '0; m_ready = 2'b01;
        #1;
        check("ovf_err_beat", {m_valid, m_last, m_err, core_in_valid}, 5'b10110);
        check("ovf_err_data", m_data, 0);
        tick();
        check("ovf_err_hold", {m_valid, m_err}, 3'b101);
        m_ready = 2'b10;
        tick();
        m_ready = '0;
        #1;
        check("ovf_idle", {busy, m_valid}, 0);
        req_valid = 2'b11;
        #1;
        check("ovf_ptr_is_0", req_ready, 2'b01);
        req_valid = '0;
        tick();

        // Timeout: core silent for 8 WAIT cycles -> ERR
        start_job(1'b0, 1'b0);
        s_valid = 2'b01; s_last = 2'b01;
        tick();
        s_valid = '0; s_last = '0;
        for (int k = 0; k < 8; k++) begin
            #1;
            check($sformatf("tmo_wait%0d", k), {m_valid, busy}, 3'b001);
            tick();
        end
        check("tmo_err", {m_valid, m_err, m_last}, 4'b0111);
        m_ready = 2'b01;
        tick();
        m_ready = '0;
        check("tmo_idle", busy, 0);

        // core_done in the final timeout cycle wins -> DRAIN
        start_job(1'b1, 1'b1);
        s_valid = 2'b10; s_last = 2'b10;
        tick();
        s_valid = '0; s_last = '0;
        repeat (7) tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        core_out_valid = 1'b1; core_out_last = 1'b1; core_out_data = 32'hCAFEF00D; m_ready = 2'b10;
        #1;
        check("tmo_done_drain", {m_valid, m_err, core_out_ready, m_last}, 5'b10011);
        check("tmo_done_data", m_data, 32'hCAFEF00D);
        tick();
        core_out_valid = 1'b0; core_out_last = 1'b0; m_ready = '0;
        check("tmo_done_idle", busy, 0);

        // Reset asserted mid-LOAD abandons the job silently
        start_job(1'b0, 1'b1);
        s_valid = 2'b01; s_data = {32'h0, 32'h12345678};
        #1;
        check("rst_load_active", {core_in_valid, s_ready}, 3'b101);
        ARESET = 1'b1;
        #1;
        check_all_zero("rst_mid");
        tick();
        s_valid = '0; s_data = '0; core_in_ready = 1'b0;
        ARESET = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("rst_after%0d", k), {m_valid, m_err, busy}, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
